// File: rtl/conv1d_sequencer.sv
// Runs one conv1d job per job_start: configures the CFU, streams per-channel params and filters,
// polls each channel's MAC run to completion and presents the quantized result downstream.
module conv1d_sequencer #(
  parameter int unsigned KERNEL_LENGTH      = 8,
  parameter int unsigned MAX_INPUT_CHANNELS = 128,
  parameter int unsigned MAX_OUT_CHANNELS   = 256,
  parameter int unsigned POLL_TIMEOUT       = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        job_start,
  input  logic [31:0] job_depth,
  input  logic [31:0] job_start_x,
  input  logic [31:0] job_out_ch,
  input  logic [31:0] job_in_off,
  input  logic [31:0] job_out_off,
  input  logic [31:0] job_act_min,
  input  logic [31:0] job_act_max,
  input  logic        prm_valid,
  output logic        prm_ready,
  input  logic [31:0] prm_bias,
  input  logic [31:0] prm_mult,
  input  logic [31:0] prm_shift,
  input  logic        flt_valid,
  output logic        flt_ready,
  input  logic [31:0] flt_data,
  output logic        cfu_en,
  output logic [6:0]  cfu_cmd,
  output logic [31:0] cfu_inp0,
  output logic [31:0] cfu_inp1,
  input  logic [31:0] cfu_ret,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [31:0] res_ch,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err
);
  localparam int unsigned PollW = $clog2(POLL_TIMEOUT + 1);

  typedef enum logic [3:0] {
    StIdle, StCfg, StPrm, StPrmCmd, StFlt, StStart, StPollIssue, StPollWait, StPollCheck,
    StRead, StReadWait, StReadLatch, StOut
  } state_e;

  state_e         state_q, state_d;
  logic [2:0]     idx_q, idx_d;
  logic [31:0]    ch_q, ch_d, w_q, w_d, words_q, words_d;
  logic [PollW-1:0] poll_q, poll_d;
  logic           gap_q, gap_d;
  logic [31:0]    depth_q, depth_d, start_x_q, start_x_d, out_ch_q, out_ch_d;
  logic [31:0]    in_off_q, in_off_d, out_off_q, out_off_d, act_min_q, act_min_d;
  logic [31:0]    act_max_q, act_max_d, mult_q, mult_d, shift_q, shift_d;
  logic           en_q, en_d;
  logic [6:0]     cmd_q, cmd_d;
  logic [31:0]    inp0_q, inp0_d, inp1_q, inp1_d;
  logic           res_valid_q, res_valid_d;
  logic [31:0]    res_data_q, res_data_d, res_ch_q, res_ch_d;
  logic           done_q, done_d;
  logic [1:0]     err_q, err_d;

  assign prm_ready = (state_q == StPrm);
  // One-cycle bubble after each accepted filter word caps the rate at one word per two cycles.
  assign flt_ready = (state_q == StFlt) && !gap_q;
  assign busy      = (state_q != StIdle);
  assign cfu_en    = en_q;
  assign cfu_cmd   = cmd_q;
  assign cfu_inp0  = inp0_q;
  assign cfu_inp1  = inp1_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_ch    = res_ch_q;
  assign done      = done_q;
  assign err       = err_q;

  always_comb begin
    state_d = state_q;     idx_d = idx_q;         ch_d = ch_q;           w_d = w_q;
    words_d = words_q;     poll_d = poll_q;       gap_d = 1'b0;
    depth_d = depth_q;     start_x_d = start_x_q; out_ch_d = out_ch_q;   in_off_d = in_off_q;
    out_off_d = out_off_q; act_min_d = act_min_q; act_max_d = act_max_q;
    mult_d = mult_q;       shift_d = shift_q;
    en_d = 1'b0;           cmd_d = 7'd0;          inp0_d = 32'd0;        inp1_d = 32'd0;
    res_valid_d = res_valid_q; res_data_d = res_data_q; res_ch_d = res_ch_q;
    done_d = 1'b0;         err_d = err_q;
    unique case (state_q)
      StIdle: begin
        if (job_start) begin
          if (job_depth == 32'd0 || job_depth > 32'(MAX_INPUT_CHANNELS) ||
              job_out_ch > 32'(MAX_OUT_CHANNELS)) begin
            err_d  = 2'd1;
            done_d = 1'b1;
          end else if (job_out_ch == 32'd0) begin
            err_d  = 2'd0;
            done_d = 1'b1;
          end else begin
            depth_d   = job_depth;   start_x_d = job_start_x; out_ch_d  = job_out_ch;
            in_off_d  = job_in_off;  out_off_d = job_out_off;
            act_min_d = job_act_min; act_max_d = job_act_max;
            words_d   = (32'(KERNEL_LENGTH) * job_depth) >> 2;
            err_d     = 2'd0;
            idx_d     = 3'd0;
            ch_d      = 32'd0;
            state_d   = StCfg;
          end
        end
      end
      StCfg: begin
        en_d  = 1'b1;
        idx_d = idx_q + 3'd1;
        case (idx_q)
          3'd0:    begin cmd_d = 7'd3;  inp1_d = in_off_q;  end
          3'd1:    begin cmd_d = 7'd5;  inp1_d = depth_q;   end
          3'd2:    begin cmd_d = 7'd8;  inp1_d = start_x_q; end
          3'd3:    begin cmd_d = 7'd13; inp1_d = act_min_q; end
          3'd4:    begin cmd_d = 7'd14; inp1_d = act_max_q; end
          default: begin cmd_d = 7'd15; inp1_d = out_off_q; state_d = StPrm; end
        endcase
      end
      StPrm: begin
        if (prm_valid) begin
          // Bias goes straight out; mult and shift follow on the next two cycles.
          en_d    = 1'b1;
          cmd_d   = 7'd10;
          inp1_d  = prm_bias;
          mult_d  = prm_mult;
          shift_d = prm_shift;
          idx_d   = 3'd0;
          state_d = StPrmCmd;
        end
      end
      StPrmCmd: begin
        en_d = 1'b1;
        if (idx_q == 3'd0) begin
          cmd_d  = 7'd11;
          inp1_d = mult_q;
          idx_d  = 3'd1;
        end else begin
          cmd_d   = 7'd12;
          inp1_d  = shift_q;
          w_d     = 32'd0;
          state_d = StFlt;
        end
      end
      StFlt: begin
        if (flt_valid && flt_ready) begin
          en_d   = 1'b1;
          cmd_d  = 7'd2;
          inp0_d = {w_q[29:0], 2'b00};
          inp1_d = flt_data;
          gap_d  = 1'b1;
          w_d    = w_q + 32'd1;
          if (w_q + 32'd1 == words_q) state_d = StStart;
        end
      end
      StStart: begin
        en_d    = 1'b1;
        cmd_d   = 7'd6;
        poll_d  = '0;
        state_d = StPollIssue;
      end
      StPollIssue: begin
        en_d    = 1'b1;
        cmd_d   = 7'd9;
        poll_d  = poll_q + PollW'(1);
        state_d = StPollWait;
      end
      StPollWait: state_d = StPollCheck;
      StPollCheck: begin
        if (cfu_ret[0]) begin
          state_d = StRead;
        end else if (poll_q == PollW'(POLL_TIMEOUT)) begin
          err_d   = 2'd2;
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          en_d    = 1'b1;
          cmd_d   = 7'd9;
          poll_d  = poll_q + PollW'(1);
          state_d = StPollWait;
        end
      end
      StRead: begin
        en_d    = 1'b1;
        cmd_d   = 7'd7;
        state_d = StReadWait;
      end
      StReadWait: state_d = StReadLatch;
      StReadLatch: begin
        res_data_d  = cfu_ret;
        res_ch_d    = ch_q;
        res_valid_d = 1'b1;
        state_d     = StOut;
      end
      StOut: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          if (ch_q + 32'd1 < out_ch_q) begin
            ch_d    = ch_q + 32'd1;
            state_d = StPrm;
          end else begin
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;    idx_q <= '0;        ch_q <= '0;         w_q <= '0;
      words_q <= '0;        poll_q <= '0;       gap_q <= 1'b0;
      depth_q <= '0;        start_x_q <= '0;    out_ch_q <= '0;     in_off_q <= '0;
      out_off_q <= '0;      act_min_q <= '0;    act_max_q <= '0;
      mult_q <= '0;         shift_q <= '0;
      en_q <= 1'b0;         cmd_q <= '0;        inp0_q <= '0;       inp1_q <= '0;
      res_valid_q <= 1'b0;  res_data_q <= '0;   res_ch_q <= '0;
      done_q <= 1'b0;       err_q <= '0;
    end else begin
      state_q <= state_d;   idx_q <= idx_d;     ch_q <= ch_d;       w_q <= w_d;
      words_q <= words_d;   poll_q <= poll_d;   gap_q <= gap_d;
      depth_q <= depth_d;   start_x_q <= start_x_d; out_ch_q <= out_ch_d; in_off_q <= in_off_d;
      out_off_q <= out_off_d; act_min_q <= act_min_d; act_max_q <= act_max_d;
      mult_q <= mult_d;     shift_q <= shift_d;
      en_q <= en_d;         cmd_q <= cmd_d;     inp0_q <= inp0_d;   inp1_q <= inp1_d;
      res_valid_q <= res_valid_d; res_data_q <= res_data_d; res_ch_q <= res_ch_d;
      done_q <= done_d;     err_q <= err_d;
    end
  end

endmodule
